// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : decoder_pkg
// Purpose : Shared decoder/scoreboard types and defaults. decoded_t is the
//           instruction record handed from the decoder to the issue stage.
// Revision: 1.0 - initial release
// ============================================================================
package decoder_pkg;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int CNT_W_DEFAULT    = 2;
  localparam int REG_IDX_W        = 5;

  // Source/destination indices plus use flags. r_* marks a source that is
  // read, w_* marks a destination that will later be written back.
  typedef struct packed {
    logic [7:0]           opcode;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rs3;
    logic                 r_rs1;
    logic                 r_rs2;
    logic                 r_rs3;
    logic                 r_flags;
    logic                 w_rd;
    logic                 w_flags;
    logic                 undefined;
  } decoded_t;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module  : sb_counter
// Purpose : Pending-write counter for one tracked resource. One increment
//           and up to NUM_WB decrements per cycle, netted together.
//           Decrementing below zero clamps at zero and raises underflow.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           clr           - clear counter (flush); suppresses underflow
//           inc           - one new outstanding write
//           dec[NUM_WB]   - one completion per asserted bit
//           nonzero       - at least one write outstanding
//           at_max        - counter saturated, no further writes accepted
//           underflow     - this cycle's decrements exceed available count
// Revision: 1.0 - initial release
// ============================================================================
module sb_counter #(
  parameter int CNT_W  = 2,
  parameter int NUM_WB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [NUM_WB-1:0] dec,
  output logic              nonzero,
  output logic              at_max,
  output logic              underflow
);

  // Wide enough to hold count + 1 and the hit count without wrapping.
  localparam int SUM_W = CNT_W + $clog2(NUM_WB + 1) + 1;
  localparam logic [SUM_W-1:0] c_MAX_CNT = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_hits;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_diff;
  logic             w_under;
  logic [CNT_W-1:0] w_next;

  always_comb begin
    w_hits = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      w_hits = w_hits + SUM_W'(dec[p]);
    end
    w_up    = SUM_W'(r_cnt) + SUM_W'(inc);
    w_under = (w_hits > w_up);
    w_diff  = w_up - w_hits;
    if (w_under) begin
      w_next = '0;
    end else if (w_diff > c_MAX_CNT) begin
      w_next = c_MAX_CNT[CNT_W-1:0];
    end else begin
      w_next = w_diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign nonzero   = |r_cnt;
  assign at_max    = &r_cnt;
  assign underflow = w_under && !clr && !rst;

endmodule : sb_counter
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : issue_scoreboard
// Purpose : Single-entry issue stage with a register/flags scoreboard.
//           Instructions stall while any source has an outstanding write or
//           the destination counter is saturated. Writebacks free entries
//           one cycle later (no same-cycle bypass).
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           flush                    - squash output entry, clear scoreboard
//           in_valid/in_ready/in_dec - decoder handshake
//           out_valid/out_ready/out_dec - issued instruction handshake
//           wb_valid/wb_rd/wb_flags  - NUM_WB writeback completions
//           sb_err                   - sticky writeback-on-zero-counter error
// Revision: 1.0 - initial release
// ============================================================================
module issue_scoreboard
  import decoder_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int NUM_WB   = 2,
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int ZERO_R0  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  decoded_t              in_dec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output decoded_t              out_dec,
  input  logic [NUM_WB-1:0]     wb_valid,
  input  logic [NUM_WB*5-1:0]   wb_rd,
  input  logic [NUM_WB-1:0]     wb_flags,
  output logic                  sb_err
);

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_full;
  logic [NUM_REGS-1:0] w_uflow;
  logic                w_fl_busy;
  logic                w_fl_full;
  logic                w_fl_uflow;

  // Padded to the full 5-bit index space so rs/rd fields index directly.
  logic [31:0]         w_reg_busy;
  logic [31:0]         w_reg_full;

  logic                w_hazard;
  logic                w_issue;
  logic                w_track_wr;

  logic                r_out_valid;
  decoded_t            r_out_dec;
  logic                r_sb_err;

  assign w_track_wr = w_issue && !in_dec.undefined;

  // --------------------------------------------------------------------------
  // Per-register counters
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    // r0 keeps its counter instance but never sees traffic when hardwired.
    localparam bit c_TRACK = !((ZERO_R0 != 0) && (i == 0));

    logic              w_inc;
    logic [NUM_WB-1:0] w_dec;

    always_comb begin
      w_inc = c_TRACK && w_track_wr && in_dec.w_rd && (in_dec.rd == 5'(i));
      for (int p = 0; p < NUM_WB; p++) begin
        w_dec[p] = c_TRACK && wb_valid[p] && (wb_rd[p*5 +: 5] == 5'(i));
      end
    end

    sb_counter #(
      .CNT_W  (CNT_W),
      .NUM_WB (NUM_WB)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .inc       (w_inc),
      .dec       (w_dec),
      .nonzero   (w_busy[i]),
      .at_max    (w_full[i]),
      .underflow (w_uflow[i])
    );
  end

  // --------------------------------------------------------------------------
  // Flags counter
  // --------------------------------------------------------------------------
  sb_counter #(
    .CNT_W  (CNT_W),
    .NUM_WB (NUM_WB)
  ) u_flags_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .inc       (w_track_wr && in_dec.w_flags),
    .dec       (wb_flags),
    .nonzero   (w_fl_busy),
    .at_max    (w_fl_full),
    .underflow (w_fl_uflow)
  );

  for (genvar i = 0; i < 32; i++) begin : g_pad
    if (i < NUM_REGS) begin : g_live
      assign w_reg_busy[i] = w_busy[i];
      assign w_reg_full[i] = w_full[i];
    end else begin : g_none
      assign w_reg_busy[i] = 1'b0;
      assign w_reg_full[i] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Hazard and handshake. Uses registered counter state only, so a writeback
  // releases a stall on the following cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hazard = 1'b0;
    if (!in_dec.undefined) begin
      w_hazard = (in_dec.r_rs1   && w_reg_busy[in_dec.rs1]) ||
                 (in_dec.r_rs2   && w_reg_busy[in_dec.rs2]) ||
                 (in_dec.r_rs3   && w_reg_busy[in_dec.rs3]) ||
                 (in_dec.r_flags && w_fl_busy)              ||
                 (in_dec.w_rd    && w_reg_full[in_dec.rd])  ||
                 (in_dec.w_flags && w_fl_full);
    end
  end

  assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush && !rst;
  assign w_issue  = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Output entry and sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sb_err    <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_issue) begin
        r_out_valid <= 1'b1;
        r_out_dec   <= in_dec;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if ((|w_uflow) || w_fl_uflow) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_dec   = r_out_dec;
  assign sb_err    = r_sb_err;

endmodule : issue_scoreboard
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_issue_scoreboard
// Purpose : Self-checking bench for issue_scoreboard. Directed scenarios and
//           randomized traffic are compared against a per-register pending
//           count model kept as plain integer arrays.
// Revision: 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;
  import decoder_pkg::*;

  localparam int NWB  = 2;
  localparam int MAXC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  decoded_t        in_dec;
  logic            out_valid;
  logic            out_ready;
  decoded_t        out_dec;
  logic [NWB-1:0]  wb_valid;
  logic [NWB*5-1:0] wb_rd;
  logic [NWB-1:0]  wb_flags;
  logic            sb_err;

  issue_scoreboard #(
    .NUM_REGS (32),
    .NUM_WB   (NWB),
    .CNT_W    (2),
    .ZERO_R0  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dec    (in_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dec   (out_dec),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_flags  (wb_flags),
    .sb_err    (sb_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Staged stimulus, applied right after the falling edge.
  logic            s_rst, s_flush, s_in_valid, s_out_ready;
  decoded_t        s_dec;
  logic [NWB-1:0]  s_wb_valid, s_wb_flags;
  logic [NWB*5-1:0] s_wb_rd;

  // Reference model: outstanding writes per register and for flags.
  int       pend [32];
  int       pflags;
  bit       m_valid;
  decoded_t m_dec;
  bit       m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit src_pending(input bit used, input logic [4:0] r);
    return used && (r != 5'd0) && (pend[r] > 0);
  endfunction

  function automatic bit model_hazard(input decoded_t d);
    if (d.undefined) return 1'b0;
    if (src_pending(d.r_rs1, d.rs1)) return 1'b1;
    if (src_pending(d.r_rs2, d.rs2)) return 1'b1;
    if (src_pending(d.r_rs3, d.rs3)) return 1'b1;
    if (d.r_flags && pflags > 0) return 1'b1;
    if (d.w_rd && d.rd != 5'd0 && pend[d.rd] >= MAXC) return 1'b1;
    if (d.w_flags && pflags >= MAXC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic decoded_t mk_dec(input logic [4:0] rd, input bit wrd,
                                      input logic [4:0] rs1, input bit rrs1,
                                      input bit wfl, input bit rfl, input bit undef);
    decoded_t d;
    d           = '0;
    d.opcode    = 8'($urandom);
    d.rd        = rd;
    d.w_rd      = wrd;
    d.rs1       = rs1;
    d.r_rs1     = rrs1;
    d.w_flags   = wfl;
    d.r_flags   = rfl;
    d.undefined = undef;
    return d;
  endfunction

  task automatic idle_stim();
    s_rst       = 1'b0;
    s_flush     = 1'b0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    s_dec       = '0;
    s_wb_valid  = '0;
    s_wb_flags  = '0;
    s_wb_rd     = '0;
  endtask

  task automatic set_wb(input int p, input logic [4:0] r, input bit fl);
    s_wb_valid[p]      = 1'b1;
    s_wb_rd[p*5 +: 5]  = r;
    s_wb_flags[p]      = fl;
  endtask

  // One clock: check registered outputs, apply stimulus, check in_ready,
  // then advance the model to the state after the coming rising edge.
  task automatic step();
    bit rdy, iss;
    int n;
    int delta [32];
    int fdelta;
    @(negedge clk);
    cyc++;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) chk("out_dec", 64'(out_dec), 64'(m_dec));
    chk("sb_err", 64'(sb_err), 64'(m_err));
    rst       = s_rst;
    flush     = s_flush;
    in_valid  = s_in_valid;
    out_ready = s_out_ready;
    in_dec    = s_dec;
    wb_valid  = s_wb_valid;
    wb_rd     = s_wb_rd;
    wb_flags  = s_wb_flags;
    #1;
    rdy = (!m_valid || s_out_ready) && !model_hazard(s_dec) && !s_flush && !s_rst;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    iss = s_in_valid && rdy;
    if (s_rst || s_flush) begin
      foreach (pend[r]) pend[r] = 0;
      pflags  = 0;
      m_valid = 1'b0;
      if (s_rst) m_err = 1'b0;
    end else begin
      if (iss) begin
        m_valid = 1'b1;
        m_dec   = s_dec;
      end else if (s_out_ready) begin
        m_valid = 1'b0;
      end
      foreach (delta[r]) delta[r] = 0;
      fdelta = 0;
      if (iss && !s_dec.undefined) begin
        if (s_dec.w_rd && s_dec.rd != 5'd0) delta[s_dec.rd]++;
        if (s_dec.w_flags) fdelta++;
      end
      for (int p = 0; p < NWB; p++) begin
        if (s_wb_valid[p] && s_wb_rd[p*5 +: 5] != 5'd0) delta[s_wb_rd[p*5 +: 5]]--;
        if (s_wb_flags[p]) fdelta--;
      end
      for (int r = 0; r < 32; r++) begin
        n = pend[r] + delta[r];
        if (n < 0) begin n = 0; m_err = 1'b1; end
        pend[r] = n;
      end
      n = pflags + fdelta;
      if (n < 0) begin n = 0; m_err = 1'b1; end
      pflags = n;
    end
  endtask

  task automatic rand_stim();
    int cand [$];
    decoded_t d;
    idle_stim();
    s_rst       = ($urandom_range(0, 299) == 0);
    s_flush     = ($urandom_range(0, 39) == 0);
    s_in_valid  = ($urandom_range(0, 3) != 0);
    s_out_ready = ($urandom_range(0, 3) != 0);
    d           = '0;
    d.opcode    = 8'($urandom);
    d.rd        = 5'($urandom_range(0, 7));
    d.rs1       = 5'($urandom_range(0, 7));
    d.rs2       = 5'($urandom_range(0, 7));
    d.rs3       = 5'($urandom_range(0, 7));
    d.w_rd      = ($urandom_range(0, 3) != 0);
    d.r_rs1     = $urandom_range(0, 1);
    d.r_rs2     = ($urandom_range(0, 2) == 0);
    d.r_rs3     = ($urandom_range(0, 4) == 0);
    d.w_flags   = ($urandom_range(0, 3) == 0);
    d.r_flags   = ($urandom_range(0, 3) == 0);
    d.undefined = ($urandom_range(0, 15) == 0);
    s_dec       = d;
    cand.delete();
    for (int r = 1; r < 32; r++) if (pend[r] > 0) cand.push_back(r);
    for (int p = 0; p < NWB; p++) begin
      if (cand.size() > 0 && $urandom_range(0, 2) == 0)
        set_wb(p, 5'(cand[$urandom_range(0, cand.size() - 1)]),
               (pflags > 0) && ($urandom_range(0, 1) == 1));
      else if ($urandom_range(0, 79) == 0)
        set_wb(p, 5'($urandom_range(0, 7)), $urandom_range(0, 1));
    end
  endtask

  initial begin
    foreach (pend[r]) pend[r] = 0;
    pflags  = 0;
    m_valid = 1'b0;
    m_dec   = '0;
    m_err   = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_dec = '0; wb_valid = '0; wb_rd = '0; wb_flags = '0;

    // Reset, including in_ready low while rst is asserted.
    idle_stim(); s_rst = 1'b1; s_in_valid = 1'b1;
    step(); step();

    // RAW on r3, released the cycle after the writeback.
    idle_stim(); s_in_valid = 1'b1; s_dec = mk_dec(5'd3, 1, 5'd0, 0, 0, 0, 0); step();
    s_dec = mk_dec(5'd1, 1, 5'd3, 1, 0, 0, 0); step(); step();
    set_wb(0, 5'd3, 0); step();
    s_wb_valid = '0; step();
    s_wb_valid = '0; set_wb(0, 5'd1, 0); s_in_valid = 1'b0; step();

    // Saturate r5, fourth write stalls until one writeback.
    idle_stim(); s_in_valid = 1'b1; s_dec = mk_dec(5'd5, 1, 5'd0, 0, 0, 0, 0);
    step(); step(); step(); step(); step();
    set_wb(1, 5'd5, 0); step();
    s_wb_valid = '0; step();
    idle_stim(); step();

    // r7 to two, both ports retire it together, then one extra writeback.
    idle_stim(); s_in_valid = 1'b1; s_dec = mk_dec(5'd7, 1, 5'd0, 0, 0, 0, 0); step(); step();
    idle_stim(); set_wb(0, 5'd7, 0); set_wb(1, 5'd7, 0); step();
    idle_stim(); step();
    set_wb(0, 5'd7, 0); step();
    idle_stim(); step(); step();

    // Back-pressure: held entry while out_ready is low, then release.
    idle_stim(); s_rst = 1'b1; step();
    idle_stim(); s_in_valid = 1'b1; s_dec = mk_dec(5'd9, 1, 5'd2, 1, 1, 0, 0); step();
    s_out_ready = 1'b0; s_dec = mk_dec(5'd10, 1, 5'd4, 1, 0, 0, 0);
    step(); step(); step(); step();
    s_out_ready = 1'b1; step();

    // Flush wins over same-cycle issue and writeback.
    s_flush = 1'b1; s_dec = mk_dec(5'd11, 1, 5'd0, 0, 1, 0, 0); set_wb(0, 5'd9, 1); step();
    idle_stim(); s_in_valid = 1'b1; s_dec = mk_dec(5'd12, 1, 5'd9, 1, 0, 1, 0); step();
    idle_stim(); step();

    // r0 never tracked; undefined instruction bypasses hazards.
    idle_stim(); s_in_valid = 1'b1; s_dec = mk_dec(5'd0, 1, 5'd0, 0, 0, 0, 0); step();
    s_dec = mk_dec(5'd4, 1, 5'd0, 1, 1, 0, 0); step();
    s_dec = mk_dec(5'd4, 1, 5'd4, 1, 1, 1, 1); step();
    s_dec = mk_dec(5'd6, 1, 5'd4, 1, 0, 0, 0); step();
    idle_stim(); set_wb(0, 5'd4, 1); step();
    idle_stim(); step(); step();

    for (int i = 0; i < 3000; i++) begin
      rand_stim();
      step();
    end
    idle_stim(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_issue_scoreboard
`default_nettype wire
